// File: rtl/frame_buffer_writer_pkg.sv
// Shared constants and FSM encoding for the frame-buffer write and read paths.
package frame_buffer_writer_pkg;

   localparam int unsigned FBW_FRAME_PIXELS = 76800;
   localparam int unsigned FBW_ADDR_W       = 18;
   localparam int unsigned FBW_PIX_W        = 5;
   localparam int unsigned FBW_CNT_W        = 8;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_SOF = 2'd1,
      ST_CAPTURE  = 2'd2,
      ST_COMMIT   = 2'd3
   } fbw_state_e;

   // Saturating increment for 8-bit event counters.
   function automatic logic [FBW_CNT_W-1:0] sat_inc8(input logic [FBW_CNT_W-1:0] v);
      return (v == {FBW_CNT_W{1'b1}}) ? v : v + FBW_CNT_W'(1);
   endfunction

endpackage

// File: rtl/frame_buffer_writer_if.sv
// Frame RAM write bus: address, data, strobe and active bank.
interface frame_buffer_writer_if
   import frame_buffer_writer_pkg::*;
#(
   parameter int unsigned ADDR_W = FBW_ADDR_W,
   parameter int unsigned PIX_W  = FBW_PIX_W
);

   logic [ADDR_W-1:0] wr_addr;
   logic [PIX_W-1:0]  wr_data;
   logic              wr_en;
   logic              wr_bank;

   modport master (output wr_addr, output wr_data, output wr_en, output wr_bank);
   modport slave  (input  wr_addr, input  wr_data, input  wr_en, input  wr_bank);

endinterface

// File: rtl/fbw_pixel_counter.sv
// Pixel position counter with clear, increment and last-pixel flag.
module fbw_pixel_counter
   import frame_buffer_writer_pkg::*;
#(
   parameter int unsigned FRAME_PIXELS = FBW_FRAME_PIXELS,
   parameter int unsigned ADDR_W       = FBW_ADDR_W
) (
   input  logic              pclk,
   input  logic              reset,
   input  logic              clear,
   input  logic              inc,
   output logic [ADDR_W-1:0] count,
   output logic              last_c
);

   // Compare against FRAME_PIXELS-1 so a full 2^ADDR_W frame never needs a wrap.
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_PIXELS - 1);

   // Counter register; clear wins over increment.
   always_ff @(posedge pclk) begin
      if (reset)      count <= '0;
      else if (clear) count <= '0;
      else if (inc)   count <= count + ADDR_W'(1);
   end

   assign last_c = (count == LAST);

endmodule

// File: rtl/frame_buffer_writer.sv
// Captures a pixel stream into ping-pong frame banks and swaps banks once the
// reader releases the other one. Optional frame checking: FBW_FRAME_CHECK_EN.
module frame_buffer_writer
   import frame_buffer_writer_pkg::*;
#(
   parameter int unsigned FRAME_PIXELS = FBW_FRAME_PIXELS,
   parameter int unsigned ADDR_W       = FBW_ADDR_W,
   parameter int unsigned PIX_W        = FBW_PIX_W
) (
   input  logic                        pclk,
   input  logic                        reset,
   input  logic                        capture_en,
   input  logic                        vsync,
   input  logic                        vde,
   input  logic [PIX_W-1:0]            pix_in,
   input  logic                        rd_busy,
   frame_buffer_writer_if.master       wbus,
   output logic                        frame_done,
   output logic [FBW_CNT_W-1:0]        frame_cnt
`ifdef FBW_FRAME_CHECK_EN
   ,
   output logic                        frame_err,
   output logic [FBW_CNT_W-1:0]        err_cnt
`endif
);

   fbw_state_e          state, state_nxt;
   logic                vsync_d;
   logic                sof;
   logic [ADDR_W-1:0]   count;
   logic                last_c;
   logic                cnt_clear, cnt_inc;
   logic                swap;
   logic                wr_en_nxt;
   logic [ADDR_W-1:0]   wr_addr_nxt, wr_addr_q;
   logic [PIX_W-1:0]    wr_data_nxt, wr_data_q;
   logic                wr_en_q, wr_bank_q;

   assign sof = vsync & ~vsync_d;

   fbw_pixel_counter #(
      .FRAME_PIXELS (FRAME_PIXELS),
      .ADDR_W       (ADDR_W)
   ) u_counter (
      .pclk   (pclk),
      .reset  (reset),
      .clear  (cnt_clear),
      .inc    (cnt_inc),
      .count  (count),
      .last_c (last_c)
   );

   // State register.
   always_ff @(posedge pclk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // vsync history for rising-edge detection.
   always_ff @(posedge pclk) begin
      if (reset) vsync_d <= 1'b0;
      else       vsync_d <= vsync;
   end

   // Next-state logic; capture_en is only honoured outside CAPTURE so a frame always completes.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:     if (capture_en) state_nxt = ST_WAIT_SOF;
         ST_WAIT_SOF: begin
            if (!capture_en) state_nxt = ST_IDLE;
            else if (sof)    state_nxt = ST_CAPTURE;
         end
         ST_CAPTURE:  if (!sof && vde && last_c) state_nxt = ST_COMMIT;
         ST_COMMIT:   if (!rd_busy) state_nxt = capture_en ? ST_WAIT_SOF : ST_IDLE;
      endcase
   end

   // Output/datapath decode; a sof inside CAPTURE restarts the frame and writes nothing.
   always_comb begin
      wr_en_nxt   = 1'b0;
      wr_addr_nxt = wr_addr_q;
      wr_data_nxt = wr_data_q;
      cnt_clear   = 1'b0;
      cnt_inc     = 1'b0;
      swap        = 1'b0;
      case (state)
         ST_WAIT_SOF: cnt_clear = capture_en & sof;
         ST_CAPTURE: begin
            if (sof) begin
               cnt_clear = 1'b1;
            end else if (vde) begin
               wr_en_nxt   = 1'b1;
               wr_addr_nxt = count;
               wr_data_nxt = pix_in;
               cnt_inc     = ~last_c;
            end
         end
         ST_COMMIT:   swap = ~rd_busy;
         default:     ;
      endcase
   end

   // Registered write bus and frame bookkeeping.
   always_ff @(posedge pclk) begin
      if (reset) begin
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         wr_en_q    <= 1'b0;
         wr_bank_q  <= 1'b0;
         frame_done <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         wr_addr_q  <= wr_addr_nxt;
         wr_data_q  <= wr_data_nxt;
         wr_en_q    <= wr_en_nxt;
         wr_bank_q  <= wr_bank_q ^ swap;
         frame_done <= swap;
         frame_cnt  <= frame_cnt + FBW_CNT_W'(swap);
      end
   end

   assign wbus.wr_addr = wr_addr_q;
   assign wbus.wr_data = wr_data_q;
   assign wbus.wr_en   = wr_en_q;
   assign wbus.wr_bank = wr_bank_q;

`ifdef FBW_FRAME_CHECK_EN
   logic left_capture;
   logic err_nxt;

   // Marks the first COMMIT cycle, where continued vde means the frame ran long.
   always_ff @(posedge pclk) begin
      if (reset) left_capture <= 1'b0;
      else       left_capture <= (state == ST_CAPTURE) && (state_nxt == ST_COMMIT);
   end

   assign err_nxt = ((state == ST_CAPTURE) && sof) ||
                    ((state == ST_COMMIT) && left_capture && vde);

   // Error pulse and saturating error count.
   always_ff @(posedge pclk) begin
      if (reset) begin
         frame_err <= 1'b0;
         err_cnt   <= '0;
      end else begin
         frame_err <= err_nxt;
         if (err_nxt) err_cnt <= sat_inc8(err_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Bench for frame_buffer_writer: two instances (1200-pixel frame, and a
// 16-pixel frame filling a 4-bit address space) share one stimulus stream.
module tb_frame_buffer_writer;

   localparam int FP_A = 1200;
   localparam int FP_B = 16;
   localparam int M_OFF = 0, M_ARMED = 1, M_CAP = 2, M_HOLD = 3;

   logic       pclk;
   logic       reset, capture_en, vsync, vde, rd_busy;
   logic [4:0] pix_in;
   logic       a_done, b_done;
   logic [7:0] a_cnt, b_cnt;
`ifdef FBW_FRAME_CHECK_EN
   logic       a_err, b_err;
   logic [7:0] a_ecnt, b_ecnt;
`endif

   int passed = 0;
   int total  = 0;

   frame_buffer_writer_if #(.ADDR_W(18), .PIX_W(5)) bus_a ();
   frame_buffer_writer_if #(.ADDR_W(4),  .PIX_W(5)) bus_b ();

   frame_buffer_writer #(.FRAME_PIXELS(FP_A), .ADDR_W(18), .PIX_W(5)) dut_a (
      .pclk(pclk), .reset(reset), .capture_en(capture_en), .vsync(vsync), .vde(vde),
      .pix_in(pix_in), .rd_busy(rd_busy), .wbus(bus_a), .frame_done(a_done), .frame_cnt(a_cnt)
`ifdef FBW_FRAME_CHECK_EN
      , .frame_err(a_err), .err_cnt(a_ecnt)
`endif
   );

   frame_buffer_writer #(.FRAME_PIXELS(FP_B), .ADDR_W(4), .PIX_W(5)) dut_b (
      .pclk(pclk), .reset(reset), .capture_en(capture_en), .vsync(vsync), .vde(vde),
      .pix_in(pix_in), .rd_busy(rd_busy), .wbus(bus_b), .frame_done(b_done), .frame_cnt(b_cnt)
`ifdef FBW_FRAME_CHECK_EN
      , .frame_err(b_err), .err_cnt(b_ecnt)
`endif
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // Reference model: frame-level view of what each writer should present after an edge.
   typedef struct {
      int fp, mode, pos, wa, wd, fcnt, ecnt;
      bit vs_prev, we, bank, done, err, just;
   } mdl_t;
   mdl_t m [2];

   function automatic void step_model(int k);
      bit sof;
      sof = vsync && !m[k].vs_prev;
      m[k].we = 0; m[k].done = 0; m[k].err = 0;
      if (reset) begin
         m[k].vs_prev = 0; m[k].mode = M_OFF; m[k].pos = 0; m[k].wa = 0; m[k].wd = 0;
         m[k].bank = 0; m[k].fcnt = 0; m[k].ecnt = 0; m[k].just = 0;
      end else begin
         m[k].vs_prev = vsync;
         case (m[k].mode)
            M_OFF: if (capture_en) m[k].mode = M_ARMED;
            M_ARMED: begin
               if (!capture_en) m[k].mode = M_OFF;
               else if (sof) begin m[k].pos = 0; m[k].mode = M_CAP; end
            end
            M_CAP: begin
               if (sof) begin
                  m[k].pos = 0; m[k].err = 1;
               end else if (vde) begin
                  m[k].we = 1; m[k].wa = m[k].pos; m[k].wd = int'(pix_in);
                  if (m[k].pos == m[k].fp - 1) begin m[k].mode = M_HOLD; m[k].just = 1; end
                  else m[k].pos++;
               end
            end
            default: begin
               if (m[k].just && vde) m[k].err = 1;
               m[k].just = 0;
               if (!rd_busy) begin
                  m[k].bank = !m[k].bank; m[k].done = 1; m[k].fcnt = (m[k].fcnt + 1) % 256;
                  m[k].mode = capture_en ? M_ARMED : M_OFF;
               end
            end
         endcase
         if (m[k].err && m[k].ecnt < 255) m[k].ecnt++;
      end
   endfunction

   function automatic logic [63:0] expv(int k);
      logic [63:0] v;
      v = 64'({18'(m[k].wa), 5'(m[k].wd), m[k].we, m[k].bank, m[k].done, 8'(m[k].fcnt)});
`ifdef FBW_FRAME_CHECK_EN
      v = (v << 9) | 64'({m[k].err, 8'(m[k].ecnt)});
`endif
      return v;
   endfunction

   function automatic logic [63:0] actv(int k);
      logic [63:0] v;
      if (k == 0) v = 64'({bus_a.wr_addr, bus_a.wr_data, bus_a.wr_en, bus_a.wr_bank, a_done, a_cnt});
      else        v = 64'({18'(bus_b.wr_addr), bus_b.wr_data, bus_b.wr_en, bus_b.wr_bank, b_done, b_cnt});
`ifdef FBW_FRAME_CHECK_EN
      if (k == 0) v = (v << 9) | 64'({a_err, a_ecnt});
      else        v = (v << 9) | 64'({b_err, b_ecnt});
`endif
      return v;
   endfunction

   // Advance one clock: model consumes the current inputs, outputs sampled 1 after the edge.
   task automatic tick();
      step_model(0);
      step_model(1);
      @(posedge pclk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) begin
         reset = 1; capture_en = 1'($urandom); vsync = 1'($urandom); vde = 1'($urandom);
         pix_in = 5'($urandom); rd_busy = 1'($urandom);
         tick();
         for (int k = 0; k < 2; k++) begin
            total++;
            if (actv(k) !== expv(k)) $display("FAIL reset_model dut%0d cyc=%0d got=%h exp=%h", k, i, actv(k), expv(k));
            else passed++;
         end
      end
      total++;
      if ({bus_a.wr_addr, bus_a.wr_data, bus_a.wr_en, bus_a.wr_bank, a_done, a_cnt} !== '0)
         $display("FAIL reset_zero got addr=%0d en=%b bank=%b done=%b cnt=%0d exp all 0",
                  bus_a.wr_addr, bus_a.wr_en, bus_a.wr_bank, a_done, a_cnt);
      else passed++;
      reset = 0; capture_en = 0; vsync = 0; vde = 0; rd_busy = 0;
   endtask

   task automatic test_full_frame();
      int wcount = 0, dones = 0, last = -1, badbank = 0;
      rd_busy = 0;
      for (int i = 0; i < 1210; i++) begin
         capture_en = 1; vsync = (i == 1); vde = (i >= 2 && i < 1202); pix_in = 5'(i - 2);
         tick();
         for (int k = 0; k < 2; k++) begin
            total++;
            if (actv(k) !== expv(k)) $display("FAIL full_frame dut%0d cyc=%0d got=%h exp=%h", k, i, actv(k), expv(k));
            else passed++;
         end
         if (bus_a.wr_en) begin
            wcount++; last = int'(bus_a.wr_addr);
            if (bus_a.wr_bank !== 1'b0) badbank++;
         end
         if (a_done) dones++;
      end
      total++; if (wcount != FP_A) $display("FAIL full_writes got=%0d exp=%0d", wcount, FP_A); else passed++;
      total++; if (last != FP_A - 1) $display("FAIL full_last_addr got=%0d exp=%0d", last, FP_A - 1); else passed++;
      total++; if (badbank != 0) $display("FAIL full_write_bank got=%0d exp=0", badbank); else passed++;
      total++; if (dones != 1) $display("FAIL full_done_pulses got=%0d exp=1", dones); else passed++;
      total++; if (bus_a.wr_bank !== 1'b1) $display("FAIL full_bank got=%b exp=1", bus_a.wr_bank); else passed++;
      total++; if (a_cnt !== 8'd1) $display("FAIL full_frame_cnt got=%0d exp=1", a_cnt); else passed++;
   endtask

   task automatic test_busy_hold();
      int late_writes = 0, dones = 0;
      rd_busy = 1; capture_en = 1;
      for (int i = 0; i < 1260; i++) begin
         vsync = (i == 0) || (i == 1220);
         vde = (i >= 1 && i < 1201) || (i >= 1221 && i < 1251);
         pix_in = 5'($urandom);
         tick();
         for (int k = 0; k < 2; k++) begin
            total++;
            if (actv(k) !== expv(k)) $display("FAIL busy_hold dut%0d cyc=%0d got=%h exp=%h", k, i, actv(k), expv(k));
            else passed++;
         end
         if (i > 1200 && bus_a.wr_en) late_writes++;
         if (a_done) dones++;
      end
      total++; if (late_writes != 0) $display("FAIL busy_dropped_writes got=%0d exp=0", late_writes); else passed++;
      total++; if (dones != 0) $display("FAIL busy_early_done got=%0d exp=0", dones); else passed++;
      rd_busy = 0; vsync = 0; vde = 0;
      tick();
      for (int k = 0; k < 2; k++) begin
         total++;
         if (actv(k) !== expv(k)) $display("FAIL busy_release dut%0d got=%h exp=%h", k, actv(k), expv(k));
         else passed++;
      end
      total++; if (a_done !== 1'b1) $display("FAIL busy_release_done got=%b exp=1", a_done); else passed++;
      total++; if (bus_a.wr_bank !== 1'b0) $display("FAIL busy_release_bank got=%b exp=0", bus_a.wr_bank); else passed++;
      total++; if (a_cnt !== 8'd2) $display("FAIL busy_release_cnt got=%0d exp=2", a_cnt); else passed++;
   endtask

   task automatic test_short_frame();
      int early_dones = 0, dones = 0;
      rd_busy = 0; capture_en = 1;
      for (int i = 0; i < 2220; i++) begin
         vsync = (i == 0) || (i == 1001); vde = (i >= 1); pix_in = 5'($urandom);
         tick();
         for (int k = 0; k < 2; k++) begin
            total++;
            if (actv(k) !== expv(k)) $display("FAIL short_frame dut%0d cyc=%0d got=%h exp=%h", k, i, actv(k), expv(k));
            else passed++;
         end
         if (a_done) begin dones++; if (i < 2202) early_dones++; end
         if (i == 1001) begin
            total++;
            if (bus_a.wr_en !== 1'b0) $display("FAIL short_sof_write got=%b exp=0", bus_a.wr_en); else passed++;
         end
         if (i == 1002) begin
            total++;
            if ({bus_a.wr_en, bus_a.wr_addr, bus_a.wr_bank} !== {1'b1, 18'd0, 1'b0})
               $display("FAIL short_restart got en=%b addr=%0d bank=%b exp en=1 addr=0 bank=0",
                        bus_a.wr_en, bus_a.wr_addr, bus_a.wr_bank);
            else passed++;
         end
      end
      total++; if (early_dones != 0) $display("FAIL short_no_commit got=%0d exp=0", early_dones); else passed++;
      total++; if (dones != 1) $display("FAIL short_final_commit got=%0d exp=1", dones); else passed++;
   endtask

   task automatic test_alt_vde();
      int bw = 0, done_cyc = -1;
      rd_busy = 0; capture_en = 1;
      for (int i = 0; i < 40; i++) begin
         vsync = (i == 0); vde = (i % 2 == 1); pix_in = 5'($urandom);
         tick();
         for (int k = 0; k < 2; k++) begin
            total++;
            if (actv(k) !== expv(k)) $display("FAIL alt_vde dut%0d cyc=%0d got=%h exp=%h", k, i, actv(k), expv(k));
            else passed++;
         end
         if (bus_b.wr_en) begin
            total++;
            if (int'(bus_b.wr_addr) != bw) $display("FAIL alt_addr got=%0d exp=%0d", bus_b.wr_addr, bw); else passed++;
            bw++;
         end
         if (b_done) done_cyc = i;
      end
      total++; if (bw != FP_B) $display("FAIL alt_writes got=%0d exp=%0d", bw, FP_B); else passed++;
      total++; if (done_cyc != 32) $display("FAIL alt_commit_cycle got=%0d exp=32", done_cyc); else passed++;
   endtask

   task automatic test_reset_mid();
      capture_en = 1; rd_busy = 0;
      for (int i = 0; i < 504; i++) begin
         reset = (i == 501); vsync = (i == 0); vde = (i >= 1); pix_in = 5'($urandom);
         tick();
         for (int k = 0; k < 2; k++) begin
            total++;
            if (actv(k) !== expv(k)) $display("FAIL reset_mid dut%0d cyc=%0d got=%h exp=%h", k, i, actv(k), expv(k));
            else passed++;
         end
         if (i == 501) begin
            total++;
            if ({bus_a.wr_addr, bus_a.wr_data, bus_a.wr_en, bus_a.wr_bank, a_done, a_cnt} !== '0)
               $display("FAIL reset_mid_zero got addr=%0d en=%b bank=%b cnt=%0d exp all 0",
                        bus_a.wr_addr, bus_a.wr_en, bus_a.wr_bank, a_cnt);
            else passed++;
         end
      end
      reset = 0;
   endtask

   task automatic test_capture_drop();
      int bw = 0, late = 0, dones = 0;
      rd_busy = 0;
      for (int i = 0; i < 80; i++) begin
         capture_en = (i < 9); vsync = (i == 1) || (i == 40) || (i == 60);
         vde = (i >= 2 && i < 30) || (i >= 41); pix_in = 5'($urandom);
         tick();
         for (int k = 0; k < 2; k++) begin
            total++;
            if (actv(k) !== expv(k)) $display("FAIL capture_drop dut%0d cyc=%0d got=%h exp=%h", k, i, actv(k), expv(k));
            else passed++;
         end
         if (bus_b.wr_en) begin bw++; if (i >= 19) late++; end
         if (b_done) dones++;
      end
      total++; if (bw != FP_B) $display("FAIL drop_writes got=%0d exp=%0d", bw, FP_B); else passed++;
      total++; if (late != 0) $display("FAIL drop_idle_writes got=%0d exp=0", late); else passed++;
      total++; if (dones != 1) $display("FAIL drop_commit got=%0d exp=1", dones); else passed++;
      total++; if (b_cnt !== 8'd1) $display("FAIL drop_frame_cnt got=%0d exp=1", b_cnt); else passed++;
   endtask

   task automatic test_random();
      vsync = 0; rd_busy = 0;
      for (int i = 0; i < 6000; i++) begin
         reset = ($urandom_range(0, 999) == 0);
         capture_en = ($urandom_range(0, 19) != 0);
         if ($urandom_range(0, 699) == 0) vsync = ~vsync;
         if ($urandom_range(0, 99) == 0) rd_busy = ~rd_busy;
         vde = ($urandom_range(0, 3) != 0);
         pix_in = 5'($urandom);
         tick();
         for (int k = 0; k < 2; k++) begin
            total++;
            if (actv(k) !== expv(k)) $display("FAIL random dut%0d cyc=%0d got=%h exp=%h", k, i, actv(k), expv(k));
            else passed++;
         end
      end
      reset = 0;
   endtask

   initial begin
      m[0] = '{fp: FP_A, default: 0};
      m[1] = '{fp: FP_B, default: 0};
      reset = 1; capture_en = 0; vsync = 0; vde = 0; rd_busy = 0; pix_in = '0;
      test_reset();
      test_full_frame();
      test_busy_hold();
      test_short_frame();
      test_alt_vde();
      test_reset_mid();
      test_capture_drop();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/frame_buffer_writer.md
Name: frame_buffer_writer

Overview:
- Write-side counterpart of the frame-buffer read path used by background subtraction.
- Captures a 5-bit pixel stream, qualified by data-enable and vsync, into a ping-pong pair of frame RAM banks.
- Generates write address, data and enable, and swaps banks only when the reader has released the other bank.
- Publishes a frame-ready pulse so the read side can begin the next frame.

Parameters:
- FRAME_PIXELS, 76800, pixels per frame (320x240); legal range 1..2^ADDR_W.
- ADDR_W, 18, write address width.
- PIX_W, 5, pixel width.

Ports:
- pclk  input  1  pixel clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- capture_en  input  1  level; high allows frames to be captured.
- vsync  input  1  frame sync; a rising edge marks start of frame.
- vde  input  1  video data enable; pix_in valid when high.
- pix_in  input  PIX_W  incoming pixel.
- rd_busy  input  1  reader is still consuming the bank not currently being written.
- wr_addr  output  ADDR_W  registered RAM write address.
- wr_data  output  PIX_W  registered RAM write data.
- wr_en  output  1  registered RAM write strobe.
- wr_bank  output  1  bank being written; the reader uses ~wr_bank.
- frame_done  output  1  one-cycle pulse on each committed bank swap.
- frame_cnt  output  8  committed-frame counter; wraps 255->0.

Behaviour:
- Reset: wr_addr=0, wr_data=0, wr_en=0, wr_bank=0, frame_done=0, frame_cnt=0, pixel counter=0, state=IDLE, vsync edge register=0.
- Reset mid-frame aborts the frame; the partially written bank is not committed and the bank does not swap.
- vsync edge detect: register vsync_d each cycle; sof = vsync & ~vsync_d.
- FSM states:
  - IDLE: wr_en=0. Go to WAIT_SOF when capture_en=1.
  - WAIT_SOF: ignore vde. On sof, clear pixel counter and go to CAPTURE. Go to IDLE if capture_en=0.
  - CAPTURE: on each cycle with vde=1, register wr_data=pix_in, wr_addr=counter, wr_en=1 (one-cycle latency from sample to strobe), then counter+1. After the write at counter==FRAME_PIXELS-1, go to COMMIT. Cycles with vde=0 give wr_en=0 and hold the counter.
  - COMMIT: wr_en=0. When rd_busy=0, toggle wr_bank, pulse frame_done for one cycle, increment frame_cnt, then go to WAIT_SOF (or IDLE if capture_en=0). While rd_busy=1, hold in COMMIT; vsync and vde are ignored, so arriving frames are dropped.
- Boundaries and simultaneous events:
  - sof during CAPTURE (short frame): restart the counter at 0 in the same bank. The sof cycle itself writes nothing, even if vde=1. No commit.
  - Extra vde pixels after FRAME_PIXELS have been written: ignored, because the FSM has left CAPTURE.
  - capture_en falling during CAPTURE: finish the current frame, commit, then go to IDLE.
  - sof and rd_busy falling in the same COMMIT cycle: the swap happens and that sof is lost; capture starts at the next sof.
  - Counter is ADDR_W wide. FRAME_PIXELS=2^ADDR_W is legal: the terminal compare uses FRAME_PIXELS-1, so the counter never wraps in CAPTURE.
- wr_addr holds its last value when wr_en=0.

Optional Feature:
- Macro: FBW_FRAME_CHECK_EN.
- When defined:
  - Extra output frame_err (1 bit, reset 0) pulses one cycle on a sof in CAPTURE (short frame).
  - It also pulses on vde=1 in the first cycle after leaving CAPTURE when the frame ended on the final pixel with no vde gap (long frame).
  - Extra output err_cnt (8 bits, saturating at 255, reset 0) counts those pulses.
- When undefined: no such ports or logic; frame behaviour is identical.

Decomposition:
- Shared package/header: FSM state encodings (IDLE, WAIT_SOF, CAPTURE, COMMIT), default FRAME_PIXELS, ADDR_W, PIX_W. The read-side address generator uses the same constants.
- One natural sub-module: fbw_pixel_counter (load/clear/increment counter with terminal-count flag at FRAME_PIXELS-1).

Test Plan:
- Reset then capture_en=1, sof, 76800 vde pixels with value = address[4:0], rd_busy=0 -> wr_en count 76800, last wr_addr=76799 in bank 0; frame_done pulses once; wr_bank=1; frame_cnt=1.
- rd_busy=1 at end of frame -> FSM holds in COMMIT; a second sof plus pixels gives no wr_en. rd_busy drops -> swap and frame_done within one cycle.
- sof after 1000 pixels (FRAME_PIXELS=76800) -> next write at address 0 in the same bank; no frame_done. With FBW_FRAME_CHECK_EN: frame_err=1 for one cycle, err_cnt=1.
- vde toggling every other cycle with FRAME_PIXELS=16 -> 16 writes at addresses 0..15; wr_en low on gap cycles; commit after the 16th write.
- reset asserted at pixel 500 -> all outputs return to reset values next edge; wr_bank stays 0; frame_cnt=0.
- capture_en dropped mid-frame (FRAME_PIXELS=16) -> frame completes and commits, FSM goes to IDLE; later sofs produce no writes.
